// File: rtl/mmp_iddmm_pkg.sv
// Shared types for the IDDMM accumulator: digit/product widths and the accumulator FSM states.
package mmp_iddmm_pkg;
    localparam int DIGIT_W = 128;

    typedef logic [DIGIT_W-1:0]   digit_t;
    typedef logic [2*DIGIT_W-1:0] prod_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } acc_state_t;
endpackage

// File: rtl/mmp_iddmm_acc128_if.sv
// Product-in / digit-out stream bundle of the IDDMM accumulator.
// slave = the accumulator, master = the multiplier/RAM side.
interface mmp_iddmm_acc128_if #(
    parameter int CNT_W = 8
);
    import mmp_iddmm_pkg::*;

    prod_t             prod_in;
    digit_t            add_in;
    logic              in_valid;
    logic              in_first;
    logic              in_last;
    logic              in_ready;
    digit_t            out_digit;
    logic [CNT_W-1:0]  out_idx;
    logic              out_valid;
    logic              out_last;
    logic              out_ready;
    logic              busy;
    logic              seq_err;

    modport master (
        output prod_in, add_in, in_valid, in_first, in_last, out_ready,
        input  in_ready, out_digit, out_idx, out_valid, out_last, busy, seq_err
    );

    modport slave (
        input  prod_in, add_in, in_valid, in_first, in_last, out_ready,
        output in_ready, out_digit, out_idx, out_valid, out_last, busy, seq_err
    );
endinterface

// File: rtl/mmp_iddmm_acc_outreg.sv
// Output holding register: keeps digit/idx/last stable until the downstream takes it.
module mmp_iddmm_acc_outreg
    import mmp_iddmm_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  digit_t           i_digit,
    input  logic [CNT_W-1:0] i_idx,
    input  logic             i_last,
    input  logic             i_ready,
    output logic             o_can_load,
    output logic             o_valid,
    output digit_t           o_digit,
    output logic [CNT_W-1:0] o_idx,
    output logic             o_last
);
    logic             r_valid;
    digit_t           r_digit;
    logic [CNT_W-1:0] r_idx;
    logic             r_last;

    // A new value may enter when the slot is empty or is being emptied this cycle.
    assign o_can_load = !r_valid || i_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_digit <= '0;
            r_idx   <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_digit <= i_digit;
            r_idx   <= i_idx;
            r_last  <= i_last;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_digit = r_digit;
    assign o_idx   = r_idx;
    assign o_last  = r_last;
endmodule

// File: rtl/mmp_iddmm_acc128.sv
// IDDMM digit accumulator: digit = low(prod + add + carry), then a final carry digit per operation.
// Optional protocol checking is enabled by defining MMP_ACC_SEQ_CHECK_EN.
module mmp_iddmm_acc128
    import mmp_iddmm_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mmp_iddmm_acc128_if.slave     bus
);
    localparam logic [CNT_W-1:0] IDX_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    acc_state_t       r_state;
    acc_state_t       w_state_next;
    digit_t           r_carry;

    logic             w_can_load;
    logic             w_in_ready;
    logic             w_in_fire;
    logic             w_flush_fire;
    logic             w_first_eff;
    logic             w_busy;
    logic             w_load;

    digit_t           w_c_eff;
    prod_t            w_sum;
    digit_t           w_load_digit;
    logic [CNT_W-1:0] w_load_idx;

    logic             w_out_valid;
    digit_t           w_out_digit;
    logic [CNT_W-1:0] w_out_idx;
    logic             w_out_last;
    logic             w_seq_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_in_fire) w_state_next = bus.in_last ? FLUSH : RUN;
            RUN:     if (w_in_fire && bus.in_last) w_state_next = FLUSH;
            FLUSH:   if (w_can_load) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_in_ready   = (r_state != FLUSH) && w_can_load;
        w_in_fire    = bus.in_valid && w_in_ready;
        w_flush_fire = (r_state == FLUSH) && w_can_load;
        // A beat arriving in IDLE always starts a new operation, flagged or not.
        w_first_eff  = bus.in_first || (r_state == IDLE);
        w_busy       = (r_state != IDLE);
        w_load       = w_in_fire || w_flush_fire;
    end

    // Sum is exact in 2*DIGIT_W bits, so the upper half is the whole carry.
    assign w_c_eff      = w_first_eff ? '0 : r_carry;
    assign w_sum        = bus.prod_in + prod_t'(bus.add_in) + prod_t'(w_c_eff);
    assign w_load_digit = w_in_fire ? w_sum[DIGIT_W-1:0] : r_carry;
    assign w_load_idx   = (w_in_fire && w_first_eff) ? '0 : (w_out_idx + IDX_ONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_carry <= '0;
        end else if (w_in_fire) begin
            r_carry <= w_sum[2*DIGIT_W-1:DIGIT_W];
        end else if (w_flush_fire) begin
            r_carry <= '0;
        end
    end

    mmp_iddmm_acc_outreg #(
        .CNT_W (CNT_W)
    ) u_outreg (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_digit    (w_load_digit),
        .i_idx      (w_load_idx),
        .i_last     (w_flush_fire),
        .i_ready    (bus.out_ready),
        .o_can_load (w_can_load),
        .o_valid    (w_out_valid),
        .o_digit    (w_out_digit),
        .o_idx      (w_out_idx),
        .o_last     (w_out_last)
    );

`ifdef MMP_ACC_SEQ_CHECK_EN
    logic r_seq_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seq_err <= 1'b0;
        end else if ((w_in_fire && (r_state == RUN) && bus.in_first) ||
                     (w_in_fire && (r_state == IDLE) && !bus.in_first) ||
                     ((r_state == FLUSH) && bus.in_valid)) begin
            r_seq_err <= 1'b1;
        end
    end

    assign w_seq_err = r_seq_err;
`else
    assign w_seq_err = 1'b0;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_digit = w_out_digit;
    assign bus.out_idx   = w_out_idx;
    assign bus.out_last  = w_out_last;
    assign bus.busy      = w_busy;
    assign bus.seq_err   = w_seq_err;
endmodule

// File: doc/mmp_iddmm_acc128.md
Name: mmp_iddmm_acc128

Overview:
- Downstream consumer of the 128x128 IDDMM multiplier output (256-bit product stream).
- Per digit, adds the product, an addend digit (previous partial-result word) and a running 128-bit carry.
- Emits one 128-bit result digit per accepted product, plus one final carry digit after the last product.
- Sits between the multiplier and the partial-result RAM write port in the Montgomery datapath.

Parameters:
- DIGIT_W, 128, digit width. Product is 2*DIGIT_W; carry is DIGIT_W.
- CNT_W, 8, width of the output digit index counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; synchronous, active-low.
- prod_in  input  2*DIGIT_W  multiplier product, delay-aligned by the upstream valid pipeline.
- add_in  input  DIGIT_W  addend digit, aligned with prod_in.
- in_valid  input  1  prod_in/add_in valid.
- in_first  input  1  first digit of an operation; clears carry.
- in_last  input  1  last digit of an operation; triggers flush.
- in_ready  output  1  input accept.
- out_digit  output  DIGIT_W  result digit.
- out_idx  output  CNT_W  digit index within the operation.
- out_valid  output  1  out_digit valid.
- out_last  output  1  final (carry) digit of the operation.
- out_ready  input  1  downstream accept.
- busy  output  1  state != IDLE.
- seq_err  output  1  sticky protocol error (see Optional Feature).

Behaviour:
- Reset: synchronous, active-low, sampled on the rising edge of clk. Clears state to IDLE, carry to 0, out_digit to 0, out_idx to 0, out_valid to 0, out_last to 0, seq_err to 0. Reset asserted mid-operation discards the operation and any pending output.
- Input transfer: occurs when in_valid && in_ready. Output transfer: occurs when out_valid && out_ready.
- in_ready = (state != FLUSH) && (!out_valid || out_ready).
- Arithmetic on each input transfer:
  - c_eff = in_first ? 0 : carry.
  - s = prod_in + add_in + c_eff, computed 2*DIGIT_W wide.
  - out_digit <= s[DIGIT_W-1:0]; carry <= s[2*DIGIT_W-1:DIGIT_W].
  - s cannot overflow 2*DIGIT_W: max product plus max addend plus carry < 2^256, so carry always stays < 2^128.
- Latency: 1 cycle. out_valid rises the cycle after an input transfer. out_valid and out_digit hold until the output transfer.
- out_idx: 0 on an in_first beat, otherwise previous value + 1. Wraps modulo 2^CNT_W with no flag.
- States:
  - IDLE: input with in_first goes to RUN, or to FLUSH if in_last is also set. Input without in_first is accepted, treated as first, and flags seq_err.
  - RUN: input with in_last goes to FLUSH.
  - FLUSH: in_ready = 0. When the current output is taken (or out_valid = 0), load out_digit = carry, out_last = 1, out_idx += 1, out_valid = 1. Clear carry and go to IDLE.
- out_last is 0 on all product digits.
- in_first during RUN: carry is restarted (c_eff = 0), out_idx resets to 0, state stays RUN, seq_err is flagged.
- first && last on the same beat: one product digit is emitted, then one carry digit.
- out_ready held low: output stalls and the input is back-pressured. No data is lost or duplicated.

Optional Feature:
- Macro: MMP_ACC_SEQ_CHECK_EN.
- Defined: seq_err is set sticky on any of the following, and is cleared only by reset:
  - in_first during RUN;
  - input in IDLE without in_first;
  - in_valid asserted while in FLUSH.
- Undefined: seq_err is tied to 0 and the check logic is absent. Datapath behaviour is identical in both builds.

Decomposition:
- Shared package mmp_iddmm_pkg holds:
  - DIGIT_W constant;
  - typedefs digit_t (DIGIT_W) and prod_t (2*DIGIT_W);
  - state enum acc_state_t {IDLE, RUN, FLUSH}.
- One sub-module: mmp_iddmm_acc_outreg, the output holding register with valid/ready and stall logic. The top module keeps the FSM and the adder.

Test Plan:
- Single beat: first=last=1, prod=2^256-2^129+1, add=2^128-1 -> digit0 = 0 (idx 0), then digit1 = 2^128-1 (idx 1, out_last = 1).
- Three beats: prod = {2^128+5, 7, 0}, add = {1, 2, 3} -> digits 6, 10, 3, then carry digit 0 with out_last = 1.
- out_ready low for 5 cycles mid-stream: in_ready = 0 throughout, out_digit stable. After release, the sequence matches the unstalled run exactly.
- in_first mid-RUN, macro defined: carry restarts, out_idx = 0, seq_err = 1 sticky. Macro undefined: seq_err stays 0 with the same data.
- rst_n low for 1 cycle during FLUSH: next cycle out_valid = 0, busy = 0, carry = 0. A following clean operation yields correct digits.
- 300-beat operation with CNT_W = 8: out_idx wraps 255 -> 0. Flush digit has idx 44.
